// File: rtl/glb_arb_pkg.sv
// Shared types and constants for the GLB stream write arbiter.
package glb_arb_pkg;

  localparam int              TOKEN_W    = 17;
  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan N positions starting at ptr, wrapping, and grant the first requester.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glb_stream_write_arb.sv
// Round-robin arbiter sharing one GLB write port among NUM_REQ token streams.
// Each stream owns a REGION_DEPTH-word address region and retires after TX_NUM
// done tokens. Optional feature macro: GLB_ARB_PERF_EN adds per-stream stall counters.
module glb_stream_write_arb
  import glb_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = 17,
  parameter  int REGION_DEPTH = 2048,
  parameter  int TX_NUM       = 1,
  localparam int ADDR_W       = $clog2(NUM_REQ * REGION_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  input  logic [NUM_REQ-1:0]        in_valid,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      glb_wr_en,
  output logic [ADDR_W-1:0]         glb_wr_addr,
  output logic [DATA_W-1:0]         glb_wr_data,
  input  logic                      glb_wr_ready,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        overflow,
  output logic                      all_done
`ifdef GLB_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]     stall_cnt
`endif
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int OW = $clog2(REGION_DEPTH) + 1;  // one extra bit to represent "region full"
  localparam int CW = $clog2(TX_NUM + 1);

  arb_state_t state, state_nxt;

  logic [NUM_REQ-1:0][DATA_W-1:0] in_tok;
  logic [NUM_REQ-1:0][OW-1:0]     wr_ptr;
  logic [NUM_REQ-1:0]             req, grant, hit;
  logic [PW-1:0]                  rr_ptr, win;
  logic                           run, slot_free, xfer, win_full;

  assign in_tok    = in_data;
  assign run       = (state == RUN);
  // Out reg can take a new token if empty or being drained this cycle.
  assign slot_free = !glb_wr_en || glb_wr_ready;
  assign req       = in_valid & ~done & {NUM_REQ{run}};
  // A flush cycle accepts nothing, so no source believes a token was consumed that is then discarded.
  assign in_ready  = grant & {NUM_REQ{run && slot_free && !flush}};
  assign hit       = in_valid & in_ready;
  assign xfer      = |hit;
  assign win_full  = (wr_ptr[win] == OW'(REGION_DEPTH));
  assign all_done  = (state == DONE);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Encode the one-hot grant into the winning stream index.
  always_comb begin
    win = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (grant[k]) win = PW'(k);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next state: flush always re-arms; DONE only once the out reg has drained.
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = ARM;
    else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        ARM:     state_nxt = RUN;
        RUN:     if (&done && !glb_wr_en) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output register: loads on a handshake, holds while GLB stalls, drops when drained.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      glb_wr_en   <= 1'b0;
      glb_wr_addr <= '0;
      glb_wr_data <= '0;
    end else if (flush) begin
      glb_wr_en   <= 1'b0;
      glb_wr_addr <= '0;
      glb_wr_data <= '0;
    end else if (xfer) begin
      // A token for a full region is accepted but never written.
      glb_wr_en <= !win_full;
      if (!win_full) begin
        glb_wr_addr <= ADDR_W'(win) * ADDR_W'(REGION_DEPTH) + ADDR_W'(wr_ptr[win]);
        glb_wr_data <= in_tok[win];
      end
    end else if (glb_wr_ready) begin
      glb_wr_en <= 1'b0;
    end

  // Round-robin pointer advances past the winner only on a transfer.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     rr_ptr <= '0;
    else if (flush) rr_ptr <= '0;
    else if (xfer)  rr_ptr <= (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_strm
    logic [OW-1:0] ptr_q;
    logic [CW-1:0] cnt_q;
    logic          done_q, ovf_q, is_done_tok;

    assign is_done_tok = (in_tok[i] == DATA_W'(DONE_TOKEN));
    assign wr_ptr[i]   = ptr_q;
    assign done[i]     = done_q;
    assign overflow[i] = ovf_q;

    // Per-stream write pointer, done-token count and sticky flags.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        ptr_q  <= '0;
        cnt_q  <= '0;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else if (flush) begin
        ptr_q  <= '0;
        cnt_q  <= '0;
        done_q <= 1'b0;
        ovf_q  <= 1'b0;
      end else if (hit[i]) begin
        if (ptr_q == OW'(REGION_DEPTH)) ovf_q <= 1'b1;
        else                            ptr_q <= ptr_q + 1'b1;
        if (is_done_tok) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(TX_NUM - 1)) done_q <= 1'b1;
        end
      end

`ifdef GLB_ARB_PERF_EN
    logic [15:0] stall_q;
    assign stall_cnt[i*16 +: 16] = stall_q;

    // Saturating count of cycles a live stream waits in RUN.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)     stall_q <= '0;
      else if (flush) stall_q <= '0;
      else if (run && in_valid[i] && !in_ready[i] && !done[i] && stall_q != 16'hFFFF)
        stall_q <= stall_q + 1'b1;
`endif
  end

endmodule

// File: tb/tb_glb_stream_write_arb.sv
// Directed bench: table of {stream, token, expected address} rows plus hand sequences.
module tb_glb_stream_write_arb;
  import glb_arb_pkg::*;

  localparam int N = 4, DW = 17, RD = 2048, AW = 13;

  logic clk = 1'b0, rst_n, flush, glb_wr_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_valid, in_ready, done, overflow, in_ready2, done2, overflow2;
  logic            glb_wr_en, all_done, glb_wr_en2, all_done2;
  logic [AW-1:0]   glb_wr_addr, glb_wr_addr2;
  logic [DW-1:0]   glb_wr_data, glb_wr_data2;
`ifdef GLB_ARB_PERF_EN
  logic [N*16-1:0] stall_cnt, stall_cnt2;
`endif

  always #5 clk = ~clk;

  glb_stream_write_arb #(.NUM_REQ(N), .DATA_W(DW), .REGION_DEPTH(RD), .TX_NUM(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .glb_wr_en(glb_wr_en), .glb_wr_addr(glb_wr_addr),
    .glb_wr_data(glb_wr_data), .glb_wr_ready(glb_wr_ready), .done(done),
    .overflow(overflow), .all_done(all_done)
`ifdef GLB_ARB_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  glb_stream_write_arb #(.NUM_REQ(N), .DATA_W(DW), .REGION_DEPTH(RD), .TX_NUM(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .glb_wr_en(glb_wr_en2), .glb_wr_addr(glb_wr_addr2),
    .glb_wr_data(glb_wr_data2), .glb_wr_ready(glb_wr_ready), .done(done2),
    .overflow(overflow2), .all_done(all_done2)
`ifdef GLB_ARB_PERF_EN
    , .stall_cnt(stall_cnt2)
`endif
  );

  typedef struct {
    int            tst;
    int            strm;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } row_t;

  row_t          tbl[$];
  row_t          vec[$];
  logic [DW-1:0] tok [N][2100];
  int            n_tok[N], rd[N];
  logic [AW-1:0] la[$];
  logic [DW-1:0] ld[$];
  bit            use2;
  logic          s_en;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic [N-1:0]  s_rdy;
  int            pass_cnt = 0, tot_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic void add(input int t, input int s, input logic [DW-1:0] d, input logic [AW-1:0] a);
    row_t r;
    r.tst = t; r.strm = s; r.data = d; r.addr = a;
    tbl.push_back(r);
  endfunction

  function automatic void reset_src();
    for (int i = 0; i < N; i++) begin n_tok[i] = 0; rd[i] = 0; end
    la.delete(); ld.delete();
  endfunction

  function automatic void load_exp(input int t);
    vec.delete();
    foreach (tbl[r]) if (tbl[r].tst == t) vec.push_back(tbl[r]);
  endfunction

  function automatic void load_tok(input int t);
    foreach (tbl[r]) if (tbl[r].tst == t) begin
      tok[tbl[r].strm][n_tok[tbl[r].strm]] = tbl[r].data;
      n_tok[tbl[r].strm]++;
    end
  endfunction

  // One clock: drive sources at negedge, sample just after, log writes, pop on handshake.
  task automatic cycle();
    logic [N-1:0] hs;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = (rd[i] < n_tok[i]);
      in_data[i*DW +: DW] = in_valid[i] ? tok[i][rd[i]] : '0;
    end
    #1;
    s_en   = use2 ? glb_wr_en2   : glb_wr_en;
    s_addr = use2 ? glb_wr_addr2 : glb_wr_addr;
    s_data = use2 ? glb_wr_data2 : glb_wr_data;
    s_rdy  = use2 ? in_ready2    : in_ready;
    hs = in_valid & s_rdy;
    if (s_en && glb_wr_ready) begin la.push_back(s_addr); ld.push_back(s_data); end
    @(posedge clk);
    for (int i = 0; i < N; i++) if (hs[i]) rd[i]++;
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush = 1'b1; cycle();
    flush = 1'b0; cycle();
  endtask

  task automatic run_writes(input int n, input int budget, input string nm, output int c);
    c = 0;
    while (la.size() < n && c < budget) begin cycle(); c++; end
    chk({nm, " write count"}, la.size(), n);
  endtask

  task automatic run_rd(input int s, input int target, input int budget, input string nm);
    int c = 0;
    while (rd[s] < target && c < budget) begin cycle(); c++; end
    chk({nm, " accepted"}, rd[s], target);
  endtask

  task automatic check_log(input string nm);
    chk({nm, " log size"}, la.size(), vec.size());
    for (int k = 0; k < vec.size(); k++)
      if (k < la.size())
        chk($sformatf("%s wr%0d", nm, k), {la[k], ld[k]}, {vec[k].addr, vec[k].data});
  endtask

  initial begin
    int c, bad;

    add(1, 0, 17'h00011, 13'd0);    add(1, 0, 17'h00012, 13'd1);
    add(1, 0, 17'h00013, 13'd2);    add(1, 0, 17'h10100, 13'd3);
    add(2, 0, 17'h00200, 13'd0);    add(2, 1, 17'h00210, 13'd2048);
    add(2, 2, 17'h00220, 13'd4096); add(2, 3, 17'h00230, 13'd6144);
    add(2, 0, 17'h00201, 13'd1);    add(2, 1, 17'h00211, 13'd2049);
    add(2, 2, 17'h00221, 13'd4097); add(2, 3, 17'h00231, 13'd6145);
    add(3, 0, 17'h00300, 13'd0);    add(3, 1, 17'h00310, 13'd2048);
    add(3, 0, 17'h00301, 13'd1);    add(3, 1, 17'h00311, 13'd2049);
    add(3, 0, 17'h00302, 13'd2);    add(3, 1, 17'h00312, 13'd2050);
    add(5, 1, 17'h00500, 13'd2048); add(5, 1, 17'h10100, 13'd2049);
    add(5, 1, 17'h00501, 13'd2050); add(5, 1, 17'h10100, 13'd2051);
    add(6, 0, 17'h00601, 13'd0);    add(6, 3, 17'h00630, 13'd6144);
    add(6, 0, 17'h00602, 13'd1);

    use2 = 1'b0; rst_n = 1'b0; flush = 1'b0; glb_wr_ready = 1'b1;
    in_valid = '0; in_data = '0;
    reset_src();
    #3;
    chk("reset outputs", {glb_wr_en, glb_wr_addr, glb_wr_data, in_ready, done, overflow, all_done}, '0);
    chk("reset outputs tx2", {glb_wr_en2, in_ready2, done2, all_done2}, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // IDLE without a flush accepts nothing.
    tok[0][0] = 17'h00001; n_tok[0] = 1;
    cycle(); cycle();
    chk("idle no ready", {s_rdy, s_en}, '0);
    chk("idle nothing taken", rd[0], 0);

    // 1: single stream, retire on done token.
    reset_src(); load_tok(1); load_exp(1);
    do_flush();
    cycle();
    chk("t1 first grant", s_rdy, 4'b0001);
    chk("t1 out reg empty", s_en, 0);
    cycle();
    chk("t1 one-cycle latency", {s_en, s_addr, s_data}, {1'b1, 13'd0, 17'h00011});
    run_writes(4, 20, "t1", c);
    check_log("t1");
    tok[0][4] = 17'h00014; n_tok[0] = 5;
    cycle(); cycle(); cycle();
    chk("t1 retired ready", s_rdy[0], 1'b0);
    chk("t1 extra ignored", rd[0], 4);
    chk("t1 done flags", {done, overflow, all_done, glb_wr_en}, {4'b0001, 4'b0000, 1'b0, 1'b0});

    // 2: all four streams, round-robin at full throughput.
    reset_src(); load_tok(2); load_exp(2);
    do_flush();
    run_writes(8, 30, "t2", c);
    chk("t2 cycles for 8 writes", c, 9);
    check_log("t2");

    // 3: GLB stall holds the out reg and blocks all readies.
    reset_src(); load_tok(3); load_exp(3);
    do_flush();
    cycle(); cycle();
    glb_wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk($sformatf("t3 stall %0d", k), {s_en, s_addr, s_data, s_rdy}, {1'b1, 13'd2048, 17'h00310, 4'b0000});
    end
    glb_wr_ready = 1'b1;
    run_writes(6, 30, "t3", c);
    cycle(); cycle(); cycle();
    check_log("t3");

    // 4: region overflow on stream 2.
    reset_src(); vec.delete();
    for (int j = 0; j < 2049; j++) tok[2][j] = 17'(j);
    tok[2][2049] = 17'h10100; n_tok[2] = 2050;
    do_flush();
    run_rd(2, 2048, 2200, "t4 region fill");
    chk("t4 no overflow yet", overflow, 4'b0000);
    cycle();
    chk("t4 token 2049 taken", rd[2], 2049);
    chk("t4 overflow set", overflow, 4'b0100);
    run_rd(2, 2050, 10, "t4 done token");
    cycle(); cycle(); cycle();
    chk("t4 done", {done, all_done}, {4'b0100, 1'b0});
    chk("t4 write count", la.size(), 2048);
    if (la.size() == 2048)
      chk("t4 last write", {la[2047], ld[2047]}, {13'd6143, 17'h007FF});
    bad = 0;
    foreach (la[k]) if (la[k] < 13'd4096 || la[k] > 13'd6143 || ld[k] == 17'h10100) bad++;
    chk("t4 writes outside region", bad, 0);

    // 5: TX_NUM=2 instance; stream 1 retires on its second done token.
    use2 = 1'b1;
    reset_src(); load_tok(5); load_exp(5);
    do_flush();
    run_rd(1, 2, 10, "t5 first done token");
    chk("t5 not done after one", done2, 4'b0000);
    run_rd(1, 4, 10, "t5 second done token");
    chk("t5 done after two", done2, 4'b0010);
    cycle();
    check_log("t5");
    for (int i = 0; i < N; i++) if (i != 1) begin
      tok[i][0] = 17'h10100; tok[i][1] = 17'h10100; n_tok[i] = 2;
    end
    c = 0;
    while (!(rd[0] == 2 && rd[2] == 2 && rd[3] == 2) && c < 30) begin cycle(); c++; end
    chk("t5 others drained", {rd[0][3:0], rd[2][3:0], rd[3][3:0]}, {4'd2, 4'd2, 4'd2});
    chk("t5 waits for out reg", {all_done2, glb_wr_en2, done2}, {1'b0, 1'b1, 4'b1111});
    c = 0;
    while (!all_done2 && c < 5) begin cycle(); c++; end
    chk("t5 all_done", all_done2, 1'b1);
    cycle(); cycle();
    chk("t5 all_done sticky", {all_done2, glb_wr_en2, in_ready2}, {1'b1, 1'b0, 4'b0000});

    // 6: flush with a full stalled out reg, then async reset mid-run.
    use2 = 1'b0;
    reset_src(); load_exp(6);
    tok[0][0] = 17'h00600; tok[0][1] = 17'h00601; tok[0][2] = 17'h00602; n_tok[0] = 3;
    tok[3][0] = 17'h00630; n_tok[3] = 1;
    do_flush();
    cycle();
    glb_wr_ready = 1'b0;
    cycle();
    chk("t6 out reg full", s_en, 1'b1);
    flush = 1'b1;
    cycle();
    chk("t6 flush clears", {glb_wr_en, done, overflow}, '0);
    chk("t6 flush drops all_done", all_done2, 1'b0);
    flush = 1'b0; glb_wr_ready = 1'b1;
    la.delete(); ld.delete();
    cycle();
    run_writes(3, 20, "t6", c);
    check_log("t6");
    tok[3][1] = 17'h10100; n_tok[3] = 2;
    run_rd(3, 2, 10, "t6 done token");
    chk("t6 pre-reset", {glb_wr_en, glb_wr_addr, glb_wr_data, done}, {1'b1, 13'd6145, 17'h10100, 4'b1000});
    #2 rst_n = 1'b0;
    #1;
    chk("async reset", {glb_wr_en, glb_wr_addr, glb_wr_data, in_ready, done, overflow, all_done}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
